ahb_master: RTL

Single-master AHB-Lite initiator that converts a simple valid/ready command stream into pipelined single-beat NONSEQ transfers. It sits directly upstream of the `ahb_slave` memory block and drives its `hselx`/`haddr`/`hwrite`/`htrans`/`hwdata` inputs. It samples that block's `hready` to advance and returns one response per completed transfer. A wait-state watchdog flags a slave that never becomes ready.

---
 rtl/ahb_master.sv | 104 ++++++++++
 1 files changed

// File: rtl/ahb_master.sv
// AHB-Lite single-master initiator: valid/ready commands become pipelined single-beat
// NONSEQ transfers, with one response per completed transfer and a wait-state watchdog.
module ahb_master #(
   parameter int unsigned addrWidth     = 8,
   parameter int unsigned dataWidth     = 32,
   parameter int unsigned timeoutCycles = 16
) (
   input  logic                 hclk,
   input  logic                 hresetn,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_write,
   input  logic [addrWidth-1:0] cmd_addr,
   input  logic [dataWidth-1:0] cmd_wdata,
   output logic                 rsp_valid,
   output logic                 rsp_write,
   output logic [dataWidth-1:0] rsp_rdata,
   output logic                 hselx,
   output logic [addrWidth-1:0] haddr,
   output logic                 hwrite,
   output logic [1:0]           htrans,
   output logic [dataWidth-1:0] hwdata,
   input  logic                 hready,
   input  logic [dataWidth-1:0] hrdata,
   output logic                 err
);

   localparam logic [1:0]  HtransIdle   = 2'b00;
   localparam logic [1:0]  HtransNonseq = 2'b10;
   localparam int unsigned CntW         = 8;

   logic [dataWidth-1:0] wdata_q;
   logic                 pending;
   logic                 pend_write;
   logic [CntW-1:0]      wd_cnt;
   logic                 accept_c;
   logic                 active_c;

   // Commands are taken only while the bus advances and the watchdog is quiet.
   assign cmd_ready = hready & ~err;
   assign accept_c  = cmd_valid & cmd_ready;
   assign active_c  = (htrans == HtransNonseq) | pending;

   // Address and data stages advance together on every ready edge.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         htrans     <= HtransIdle;
         hselx      <= 1'b0;
         haddr      <= '0;
         hwrite     <= 1'b0;
         wdata_q    <= '0;
         hwdata     <= '0;
         pending    <= 1'b0;
         pend_write <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_write  <= 1'b0;
         rsp_rdata  <= '0;
      end else begin
         rsp_valid <= 1'b0;
         if (hready) begin
            pending    <= (htrans == HtransNonseq);
            pend_write <= hwrite;
            if (htrans == HtransNonseq) begin
               hwdata <= wdata_q;
            end
            if (pending) begin
               rsp_valid <= 1'b1;
               rsp_write <= pend_write;
               if (!pend_write) begin
                  rsp_rdata <= hrdata;
               end
            end
            if (accept_c) begin
               haddr   <= cmd_addr;
               hwrite  <= cmd_write;
               wdata_q <= cmd_wdata;
               htrans  <= HtransNonseq;
               hselx   <= 1'b1;
            end else begin
               htrans  <= HtransIdle;
               hselx   <= 1'b0;
            end
         end
      end
   end

   // Watchdog: consecutive stalled edges with a transfer in flight; saturates at the limit.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         wd_cnt <= '0;
         err    <= 1'b0;
      end else if (hready) begin
         wd_cnt <= '0;
      end else if (active_c) begin
         if (wd_cnt != CntW'(timeoutCycles)) begin
            wd_cnt <= wd_cnt + CntW'(1);
         end
         if (wd_cnt == CntW'(timeoutCycles - 1)) begin
            err <= 1'b1;
         end
      end
   end

endmodule
